// File: rtl/bcmp_seq.sv
// bcmp_seq: bit-serial RISC-V branch comparator.
// Operands are scanned one bit per cycle, MSB first. The first differing
// bit decides lt/gt; the MSB of a signed compare has inverted sense.
// With EARLY_EXIT=1 the scan stops at that bit; with EARLY_EXIT=0 it always
// walks all WIDTH bits so the latency does not depend on the operand data.
// resp_valid is raised one cycle after entering DONE, which gives a result
// latency of 1+scan_cycles cycles after the accepting edge.
module bcmp_seq #(
    parameter int WIDTH      = 32,
    parameter int EARLY_EXIT = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [WIDTH-1:0]         a,
    input  logic [WIDTH-1:0]         b,
    input  logic [2:0]               funct3,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic                     taken,
    output logic                     lt,
    output logic                     eq,
    output logic                     gt,
    output logic                     illegal,
    output logic [$clog2(WIDTH):0]   scan_cycles
);

    localparam int IDX_W = $clog2(WIDTH);
    localparam int CW    = IDX_W + 1;
    localparam logic [IDX_W-1:0] IDX_MSB  = IDX_W'(WIDTH - 1);
    localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'(0);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [CW-1:0]    CNT_ZERO = CW'(0);
    localparam logic [CW-1:0]    CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // funct3 010 and 011 have no branch meaning
    function automatic logic f_is_illegal(input logic [2:0] f3);
        f_is_illegal = (f3 == 3'b010) || (f3 == 3'b011);
    endfunction

    // BLT and BGE compare two's-complement values
    function automatic logic f_is_signed(input logic [2:0] f3);
        f_is_signed = (f3 == 3'b100) || (f3 == 3'b101);
    endfunction

    // Branch condition from the comparison flags
    function automatic logic f_taken(input logic [2:0] f3, input logic is_lt, input logic is_eq);
        case (f3)
            3'b000:  f_taken = is_eq;
            3'b001:  f_taken = !is_eq;
            3'b100:  f_taken = is_lt;
            3'b110:  f_taken = is_lt;
            3'b101:  f_taken = !is_lt;
            3'b111:  f_taken = !is_lt;
            default: f_taken = 1'b0;
        endcase
    endfunction

    state_t             r_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [2:0]         r_funct3;
    logic [IDX_W-1:0]   r_idx;
    logic [CW-1:0]      r_scan_cycles;
    logic               r_found;
    logic               r_found_lt;
    logic               r_req_ready;
    logic               r_resp_valid;
    logic               r_taken;
    logic               r_lt;
    logic               r_eq;
    logic               r_gt;
    logic               r_illegal;

    logic               w_a_bit;
    logic               w_b_bit;
    logic               w_diff;
    logic               w_bit_lt;
    logic               w_res_lt;
    logic               w_res_eq;
    logic               w_res_gt;
    logic               w_last;

    // Per-cycle bit compare and the result the scan would latch this cycle
    always_comb begin
        w_a_bit  = r_a[r_idx];
        w_b_bit  = r_b[r_idx];
        w_diff   = w_a_bit ^ w_b_bit;
        if (f_is_signed(r_funct3) && (r_idx == IDX_MSB)) begin
            w_bit_lt = w_a_bit;
        end else begin
            w_bit_lt = w_b_bit;
        end
        if (r_found) begin
            w_res_lt = r_found_lt;
            w_res_eq = 1'b0;
        end else if (w_diff) begin
            w_res_lt = w_bit_lt;
            w_res_eq = 1'b0;
        end else begin
            w_res_lt = 1'b0;
            w_res_eq = 1'b1;
        end
        w_res_gt = !w_res_lt && !w_res_eq;
        if (EARLY_EXIT != 0) begin
            w_last = w_diff || (r_idx == IDX_ZERO);
        end else begin
            w_last = (r_idx == IDX_ZERO);
        end
    end

    // Control FSM with operand, index, counter and result registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state       <= S_IDLE;
            r_a           <= {WIDTH{1'b0}};
            r_b           <= {WIDTH{1'b0}};
            r_funct3      <= 3'b000;
            r_idx         <= IDX_ZERO;
            r_scan_cycles <= CNT_ZERO;
            r_found       <= 1'b0;
            r_found_lt    <= 1'b0;
            r_req_ready   <= 1'b1;
            r_resp_valid  <= 1'b0;
            r_taken       <= 1'b0;
            r_lt          <= 1'b0;
            r_eq          <= 1'b0;
            r_gt          <= 1'b0;
            r_illegal     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_resp_valid <= 1'b0;
                    if (req_valid) begin
                        r_a           <= a;
                        r_b           <= b;
                        r_funct3      <= funct3;
                        r_idx         <= IDX_MSB;
                        r_scan_cycles <= CNT_ZERO;
                        r_found       <= 1'b0;
                        r_found_lt    <= 1'b0;
                        r_req_ready   <= 1'b0;
                        r_taken       <= 1'b0;
                        r_lt          <= 1'b0;
                        r_eq          <= 1'b0;
                        r_gt          <= 1'b0;
                        if (f_is_illegal(funct3)) begin
                            r_illegal <= 1'b1;
                            r_state   <= S_DONE;
                        end else begin
                            r_illegal <= 1'b0;
                            r_state   <= S_SCAN;
                        end
                    end else begin
                        r_req_ready <= 1'b1;
                    end
                end
                S_SCAN: begin
                    r_scan_cycles <= r_scan_cycles + CNT_ONE;
                    if (w_diff && !r_found) begin
                        r_found    <= 1'b1;
                        r_found_lt <= w_bit_lt;
                    end else begin
                        r_found    <= r_found;
                    end
                    if (w_last) begin
                        r_lt    <= w_res_lt;
                        r_eq    <= w_res_eq;
                        r_gt    <= w_res_gt;
                        r_taken <= f_taken(r_funct3, w_res_lt, w_res_eq);
                        r_state <= S_DONE;
                    end else begin
                        r_idx   <= r_idx - IDX_ONE;
                    end
                end
                S_DONE: begin
                    if (r_resp_valid && resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_req_ready  <= 1'b1;
                        r_state      <= S_IDLE;
                    end else begin
                        r_resp_valid <= 1'b1;
                    end
                end
                default: begin
                    r_resp_valid <= 1'b0;
                    r_req_ready  <= 1'b1;
                    r_state      <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready   = r_req_ready;
    assign resp_valid  = r_resp_valid;
    assign taken       = r_taken;
    assign lt          = r_lt;
    assign eq          = r_eq;
    assign gt          = r_gt;
    assign illegal     = r_illegal;
    assign scan_cycles = r_scan_cycles;

endmodule
